// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC block: output-phase FSM states,
// default CRC width and the polynomial used by the sibling LFSR.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int CRC_WIDTH_DEFAULT = 8;

  // CRC-8 (x^8 + x^2 + x + 1), implicit top bit.
  localparam logic [7:0] CRC_POLY = 8'h07;

endpackage : crc_pkg

// File: rtl/crc_valid_counter_if.sv
// Frame qualifier in, shift-out valid back: the handshake between the CRC
// data source and the output-phase controller.
interface crc_valid_counter_if;

  logic active;
  logic valid;

  modport master (output active, input  valid);
  modport slave  (input  active, output valid);

endinterface : crc_valid_counter_if

// File: rtl/crc_valid_counter.sv
// Output-phase controller: after a frame's active phase ends, holds valid
// high for exactly CRC_WIDTH cycles while the CRC register is shifted out.
module crc_valid_counter
  import crc_pkg::*;
#(
  parameter  int CRC_WIDTH = CRC_WIDTH_DEFAULT,
  localparam int CNT_W     = $clog2(CRC_WIDTH + 1)
) (
  input logic                clk,
  input logic                rst,
  crc_valid_counter_if.slave bus
);

  if (CRC_WIDTH < 1 || CRC_WIDTH > 255) begin : g_bad_width
    $error("crc_valid_counter: CRC_WIDTH must be within 1..255");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CRC_WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             valid_q, valid_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.active) state_d = DATA;
      end

      DATA: begin
        if (!bus.active) begin
          state_d = SHIFT;
          cnt_d   = CNT_LOAD;
          valid_d = 1'b1;
        end
      end

      SHIFT: begin
        // A new frame during shift-out wins; the remaining bits are dropped.
        if (bus.active) begin
          state_d = DATA;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.valid = valid_q;

endmodule : crc_valid_counter

// File: tb/tb_crc_valid_counter.sv
// Bench for crc_valid_counter: three instances (CRC_WIDTH 8, 1, 16) share
// one active stream; frame table plus hand-written reset sequences.
module tb_crc_valid_counter;

  logic clk = 1'b0;
  logic rst;

  crc_valid_counter_if if8 ();
  crc_valid_counter_if if1 ();
  crc_valid_counter_if if16 ();

  crc_valid_counter #(.CRC_WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  crc_valid_counter #(.CRC_WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  crc_valid_counter #(.CRC_WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  always #10 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int len8;
    int len1;
    int len16;
  } frame_t;

  typedef struct {
    logic v8;
    logic v1;
    logic v16;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic set_active(input logic a);
    if8.active  = a;
    if1.active  = a;
    if16.active = a;
  endtask

  // Drive one cycle of stimulus (called at a negedge), push the expectation,
  // then pop and compare shortly after the following rising edge.
  task automatic step(input logic a, input logic e8, input logic e1, input logic e16,
                      input string tag);
    exp_t e;
    set_active(a);
    e.v8 = e8; e.v1 = e1; e.v16 = e16;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " w8"},  if8.valid,  e.v8);
      check({tag, " w1"},  if1.valid,  e.v1);
      check({tag, " w16"}, if16.valid, e.v16);
    end
    @(negedge clk);
  endtask

  // One frame: hi cycles of active=1, then lo cycles of active=0. Valid is
  // expected low during the active phase and high on the first lenN edges
  // of the idle phase.
  task automatic run_frame(input frame_t f, input string tag);
    for (int k = 0; k < f.hi; k++)
      step(1'b1, 1'b0, 1'b0, 1'b0, {tag, " data"});
    for (int j = 0; j < f.lo; j++)
      step(1'b0, j < f.len8, j < f.len1, j < f.len16, {tag, " shift"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t frames[7];

    frames[0] = '{hi: 8, lo: 10, len8: 8, len1: 1, len16: 10}; // long frame
    frames[1] = '{hi: 2, lo: 12, len8: 8, len1: 1, len16: 12}; // short frame
    frames[2] = '{hi: 1, lo: 16, len8: 8, len1: 1, len16: 16}; // single cycle
    frames[3] = '{hi: 4, lo: 3,  len8: 3, len1: 1, len16: 3};  // aborted
    frames[4] = '{hi: 5, lo: 20, len8: 8, len1: 1, len16: 16}; // after abort
    frames[5] = '{hi: 3, lo: 9,  len8: 8, len1: 1, len16: 9};  // ends at IDLE
    frames[6] = '{hi: 1, lo: 18, len8: 8, len1: 1, len16: 16}; // back-to-back

    // Reset held for 20 ns with active low, spanning one rising edge.
    rst = 1'b0;
    set_active(1'b0);
    #5;
    check("reset w8",  if8.valid,  1'b0);
    check("reset w1",  if1.valid,  1'b0);
    check("reset w16", if16.valid, 1'b0);
    #10;
    check("reset edge w8",  if8.valid,  1'b0);
    check("reset edge w16", if16.valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Active low in IDLE must never produce valid.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, "idle low");

    for (int f = 0; f < 7; f++)
      run_frame(frames[f], $sformatf("frame%0d", f));

    // Asynchronous reset in the middle of shift-out.
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 1'b0, 1'b0, "prerst data");
    step(1'b0, 1'b1, 1'b1, 1'b1, "prerst shift");
    step(1'b0, 1'b1, 1'b0, 1'b1, "prerst shift");
    #3;
    rst = 1'b0;
    #1;
    check("async rst w8",  if8.valid,  1'b0);
    check("async rst w16", if16.valid, 1'b0);
    @(posedge clk);
    #1;
    check("rst hold w8",  if8.valid,  1'b0);
    check("rst hold w16", if16.valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // After release a fresh active phase is required.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, "post rst idle");
    run_frame(frames[2], "post rst frame");

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_crc_valid_counter
